// File: rtl/multicycle_control_if.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control_if
//  Description : Signal bundle between the multicycle sequencing controller
//                and the datapath / unified memory. The controller uses the
//                master modport; the datapath (or a testbench) uses slave.
//  Signals     : run, opcode, funct3, mem_ready, alu_zero, alu_lt  (to ctrl)
//                mem_req, mem_we, iord, ir_write, pc_write, pc_src,
//                alusrca, alusrcb, aluop, regwrite, wb_sel, retire,
//                illegal, instret, state                        (from ctrl)
//  Revision    : 1.0  initial release
// ============================================================================
interface multicycle_control_if;
    // Inputs to the controller
    logic        run;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        mem_ready;
    logic        alu_zero;
    logic        alu_lt;

    // Control lines driven by the controller
    logic        mem_req;
    logic        mem_we;
    logic        iord;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic        alusrca;
    logic [1:0]  alusrcb;
    logic [1:0]  aluop;
    logic        regwrite;
    logic [1:0]  wb_sel;
    logic        retire;
    logic        illegal;
    logic [31:0] instret;
    logic [3:0]  state;

    modport master (
        input  run, opcode, funct3, mem_ready, alu_zero, alu_lt,
        output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               alusrca, alusrcb, aluop, regwrite, wb_sel,
               retire, illegal, instret, state
    );

    modport slave (
        output run, opcode, funct3, mem_ready, alu_zero, alu_lt,
        input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
               alusrca, alusrcb, aluop, regwrite, wb_sel,
               retire, illegal, instret, state
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Sequencing controller for the multicycle RV32I-subset core.
//                Walks each instruction through FETCH / DECODE / EXEC /
//                ADDR / MEM / WB / BRANCH / JUMP, drives the shared datapath
//                control lines, handshakes with a variable-latency unified
//                memory and counts retired instructions.
//  Ports       : clk   - system clock, rising edge
//                rst_n - asynchronous active-low reset
//                bus   - multicycle_control_if.master (handshake, decode
//                        inputs, datapath control outputs, status)
//  Revision    : 1.0  initial release
// ============================================================================
module multicycle_control (
    input  wire logic               clk,
    input  wire logic               rst_n,
    multicycle_control_if.master    bus
);

    // Opcodes recognised by the decoder
    localparam logic [6:0] c_OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] c_OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;

    // State codes follow the listing order; they are visible on bus.state.
    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM    = 4'd5,
        S_WB     = 4'd6,
        S_BRANCH = 4'd7,
        S_JUMP   = 4'd8,
        S_TRAP   = 4'd9
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    state_t      w_decode_next;

    logic [31:0] r_instret;
    logic        r_illegal;
    logic        r_retire;

    // Instruction class captured while in DECODE so later states do not
    // depend on the IR staying untouched.
    logic        r_is_rtype;
    logic        r_is_store;
    logic        r_is_load;
    logic [2:0]  r_br_f3;

    logic        w_retiring;
    logic        w_taken;

    logic        w_mem_req;
    logic        w_mem_we;
    logic        w_iord;
    logic        w_ir_write;
    logic        w_pc_write;
    logic        w_pc_src;
    logic        w_alusrca;
    logic [1:0]  w_alusrcb;
    logic [1:0]  w_aluop;
    logic        w_regwrite;
    logic [1:0]  w_wb_sel;

    // ------------------------------------------------------------------
    // Opcode decode: next state out of DECODE
    // ------------------------------------------------------------------
    always_comb begin
        w_decode_next = S_TRAP;
        case (bus.opcode)
            c_OP_RTYPE,
            c_OP_ITYPE:  w_decode_next = S_EXEC;
            c_OP_LOAD,
            c_OP_STORE:  w_decode_next = S_ADDR;
            c_OP_BRANCH: begin
                // Only beq / bne / blt are implemented.
                if ((bus.funct3 == 3'b000) || (bus.funct3 == 3'b001) ||
                    (bus.funct3 == 3'b100)) begin
                    w_decode_next = S_BRANCH;
                end else begin
                    w_decode_next = S_TRAP;
                end
            end
            c_OP_JAL:    w_decode_next = S_JUMP;
            default:     w_decode_next = S_TRAP;
        endcase
    end

    // ------------------------------------------------------------------
    // Branch condition from the latched funct3
    // ------------------------------------------------------------------
    always_comb begin
        w_taken = 1'b0;
        case (r_br_f3)
            3'b000:  w_taken = bus.alu_zero;
            3'b001:  w_taken = !bus.alu_zero;
            3'b100:  w_taken = bus.alu_lt;
            default: w_taken = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM next-state and control outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_retiring   = 1'b0;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        w_iord       = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_src     = 1'b0;
        w_alusrca    = 1'b0;
        w_alusrcb    = 2'b00;
        w_aluop      = 2'b00;
        w_regwrite   = 1'b0;
        w_wb_sel     = 2'b00;

        case (r_state)
            S_IDLE: begin
                if (bus.run) begin
                    w_next_state = S_FETCH;
                end
            end

            S_FETCH: begin
                // PC <= PC + 4 and IR load happen on the completing cycle.
                w_mem_req  = 1'b1;
                w_alusrcb  = 2'b01;
                w_ir_write = bus.mem_ready;
                w_pc_write = bus.mem_ready;
                if (bus.mem_ready) begin
                    w_next_state = S_DECODE;
                end
            end

            S_DECODE: begin
                // PC + imm lands in ALUOut as the branch / jump target.
                w_alusrcb    = 2'b10;
                w_next_state = w_decode_next;
            end

            S_EXEC: begin
                w_alusrca    = 1'b1;
                w_aluop      = 2'b10;
                w_alusrcb    = r_is_rtype ? 2'b00 : 2'b10;
                w_next_state = S_WB;
            end

            S_ADDR: begin
                w_alusrca    = 1'b1;
                w_alusrcb    = 2'b10;
                w_next_state = S_MEM;
            end

            S_MEM: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                w_mem_we  = r_is_store;
                if (bus.mem_ready) begin
                    if (r_is_store) begin
                        w_retiring = 1'b1;
                    end else begin
                        w_next_state = S_WB;
                    end
                end
            end

            S_WB: begin
                w_regwrite = 1'b1;
                w_wb_sel   = r_is_load ? 2'b01 : 2'b00;
                w_retiring = 1'b1;
            end

            S_BRANCH: begin
                w_alusrca  = 1'b1;
                w_aluop    = 2'b01;
                w_pc_src   = 1'b1;
                w_pc_write = w_taken;
                w_retiring = 1'b1;
            end

            S_JUMP: begin
                // PC already holds PC + 4, which becomes the link value.
                w_pc_write = 1'b1;
                w_pc_src   = 1'b1;
                w_regwrite = 1'b1;
                w_wb_sel   = 2'b10;
                w_retiring = 1'b1;
            end

            S_TRAP: begin
                w_next_state = S_TRAP;
            end

            default: begin
                w_next_state = S_IDLE;
            end
        endcase

        // run is sampled only at instruction boundaries.
        if (w_retiring) begin
            w_next_state = bus.run ? S_FETCH : S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Status counters and latched instruction class
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret  <= 32'd0;
            r_illegal  <= 1'b0;
            r_retire   <= 1'b0;
            r_is_rtype <= 1'b0;
            r_is_store <= 1'b0;
            r_is_load  <= 1'b0;
            r_br_f3    <= 3'b000;
        end else begin
            // retire is registered so it carries no path from mem_ready;
            // it pulses in the cycle where instret shows the new count.
            r_retire <= w_retiring;
            if (w_retiring) begin
                r_instret <= r_instret + 32'd1;
            end
            if (w_next_state == S_TRAP) begin
                r_illegal <= 1'b1;
            end
            if (r_state == S_DECODE) begin
                r_is_rtype <= (bus.opcode == c_OP_RTYPE);
                r_is_store <= (bus.opcode == c_OP_STORE);
                r_is_load  <= (bus.opcode == c_OP_LOAD);
                r_br_f3    <= bus.funct3;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output drive
    // ------------------------------------------------------------------
    assign bus.mem_req  = w_mem_req;
    assign bus.mem_we   = w_mem_we;
    assign bus.iord     = w_iord;
    assign bus.ir_write = w_ir_write;
    assign bus.pc_write = w_pc_write;
    assign bus.pc_src   = w_pc_src;
    assign bus.alusrca  = w_alusrca;
    assign bus.alusrcb  = w_alusrcb;
    assign bus.aluop    = w_aluop;
    assign bus.regwrite = w_regwrite;
    assign bus.wb_sel   = w_wb_sel;
    assign bus.retire   = r_retire;
    assign bus.illegal  = r_illegal;
    assign bus.instret  = r_instret;
    assign bus.state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Self-checking bench for multicycle_control. Random
//                instruction streams with random memory wait states; each
//                issued instruction pushes its expected per-instruction
//                profile, and a monitor compares on every retire pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic       az;
        logic       alt;
    } instr_t;

    typedef struct {
        int         instret;
        int         cycles;
        int         memreq;
        int         memwe;
        int         regwr;
        int         pcwr;
        int         irwr;
        int         pcsrc;
        int         srca;
        logic [1:0] wbsel;
    } exp_t;

    instr_t instr_q[$];
    int     wait_q[$];
    exp_t   exp_q[$];

    int errors = 0;
    int checks = 0;
    int n_ret  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outvec();
        return {12'd0, bus.mem_req, bus.mem_we, bus.iord, bus.ir_write, bus.pc_write,
                bus.pc_src, bus.alusrca, bus.alusrcb, bus.aluop, bus.regwrite,
                bus.wb_sel, bus.retire, bus.illegal, bus.state};
    endfunction

    // ------------------------------------------------------------------
    // Memory / IR responder: serves requests with queued wait counts and
    // presents the next instruction once a fetch completes.
    // ------------------------------------------------------------------
    int     wcnt = -1;
    instr_t cur;
    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            wcnt          = -1;
            bus.mem_ready = 1'b0;
        end else if (bus.mem_req) begin
            if (wcnt < 0) wcnt = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
            if (wcnt == 0) begin
                bus.mem_ready = 1'b1;
                wcnt          = -1;
                if (!bus.iord && instr_q.size() > 0) begin
                    cur           = instr_q.pop_front();
                    bus.opcode    = cur.op;
                    bus.funct3    = cur.f3;
                    bus.alu_zero  = cur.az;
                    bus.alu_lt    = cur.alt;
                end
            end else begin
                bus.mem_ready = 1'b0;
                wcnt          = wcnt - 1;
            end
        end else begin
            // Stray ready pulses with no request outstanding.
            bus.mem_ready = 1'($urandom_range(0, 1));
        end
    end

    // ------------------------------------------------------------------
    // Monitor: accumulate per-instruction activity, compare on retire
    // ------------------------------------------------------------------
    int a_cyc, a_mr, a_mw, a_rw, a_pw, a_iw, a_ps, a_sa;
    logic [1:0] a_wb;
    exp_t e;

    task automatic clear_acc();
        a_cyc = 0; a_mr = 0; a_mw = 0; a_rw = 0;
        a_pw  = 0; a_iw = 0; a_ps = 0; a_sa = 0; a_wb = 2'b00;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            clear_acc();
        end else begin
            if (bus.retire) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_retire: got retire=1 expected 0 (instret=%0d)", bus.instret);
                end else begin
                    e = exp_q.pop_front();
                    chk("instret",        bus.instret, e.instret);
                    chk("cycles",         a_cyc, e.cycles);
                    chk("mem_req_cycles", a_mr,  e.memreq);
                    chk("mem_we_cycles",  a_mw,  e.memwe);
                    chk("regwrite_cycles",a_rw,  e.regwr);
                    chk("pc_write_cycles",a_pw,  e.pcwr);
                    chk("ir_write_cycles",a_iw,  e.irwr);
                    chk("pc_src_cycles",  a_ps,  e.pcsrc);
                    chk("alusrca_cycles", a_sa,  e.srca);
                    chk("wb_sel",         a_wb,  e.wbsel);
                end
                clear_acc();
            end
            if (bus.state != 4'd0 && bus.state != 4'd9) begin
                a_cyc++;
                if (bus.mem_req)  a_mr++;
                if (bus.mem_we)   a_mw++;
                if (bus.regwrite) begin a_rw++; a_wb = bus.wb_sel; end
                if (bus.pc_write) a_pw++;
                if (bus.ir_write) a_iw++;
                if (bus.pc_src)   a_ps++;
                if (bus.alusrca)  a_sa++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_raw(input logic [6:0] op, input logic [2:0] f3,
                            input logic az, input logic alt);
        instr_t ins;
        ins.op = op; ins.f3 = f3; ins.az = az; ins.alt = alt;
        instr_q.push_back(ins);
    endtask

    // cls: 0=R 1=I 2=lw 3=sw 4=branch 5=jal
    task automatic issue(input int cls);
        exp_t x;
        int   fw, mw, k;
        logic az, alt, taken;
        logic [2:0] f3;
        fw  = $urandom_range(0, 3);
        mw  = $urandom_range(0, 3);
        az  = 1'($urandom_range(0, 1));
        alt = 1'($urandom_range(0, 1));
        f3  = 3'($urandom_range(0, 7));
        n_ret++;
        x.instret = n_ret; x.irwr = 1; x.memwe = 0; x.pcsrc = 0; x.wbsel = 2'b00;
        wait_q.push_back(fw);
        case (cls)
            0, 1: begin
                push_raw(cls == 0 ? 7'b0110011 : 7'b0010011, f3, az, alt);
                x.cycles = 4 + fw; x.memreq = 1 + fw; x.regwr = 1; x.pcwr = 1; x.srca = 1;
            end
            2: begin
                push_raw(7'b0000011, 3'b010, az, alt);
                wait_q.push_back(mw);
                x.cycles = 5 + fw + mw; x.memreq = 2 + fw + mw; x.regwr = 1;
                x.pcwr = 1; x.srca = 1; x.wbsel = 2'b01;
            end
            3: begin
                push_raw(7'b0100011, 3'b010, az, alt);
                wait_q.push_back(mw);
                x.cycles = 4 + fw + mw; x.memreq = 2 + fw + mw; x.memwe = 1 + mw;
                x.regwr = 0; x.pcwr = 1; x.srca = 1;
            end
            4: begin
                k  = $urandom_range(0, 2);
                f3 = (k == 0) ? 3'b000 : (k == 1) ? 3'b001 : 3'b100;
                taken = (f3 == 3'b000) ? az : (f3 == 3'b001) ? !az : alt;
                push_raw(7'b1100011, f3, az, alt);
                x.cycles = 3 + fw; x.memreq = 1 + fw; x.regwr = 0;
                x.pcwr = 1 + int'(taken); x.pcsrc = 1; x.srca = 1;
            end
            default: begin
                push_raw(7'b1101111, f3, az, alt);
                x.cycles = 3 + fw; x.memreq = 1 + fw; x.regwr = 1;
                x.pcwr = 2; x.pcsrc = 1; x.srca = 0; x.wbsel = 2'b10;
            end
        endcase
        exp_q.push_back(x);
    endtask

    task automatic wait_fetched(input int budget, input string nm);
        int n = 0;
        while (instr_q.size() != 0 && n < budget) begin tick(); n++; end
        if (instr_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s: fetch timeout after %0d cycles", nm, budget);
        end
    endtask

    task automatic wait_state(input logic [3:0] s, input int budget, input string nm);
        int n = 0;
        while (bus.state != s && n < budget) begin tick(); n++; end
        chk(nm, bus.state, s);
    endtask

    task automatic wait_retired(input int budget, input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin tick(); n++; end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s: %0d retires outstanding after %0d cycles", nm, exp_q.size(), budget);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        instr_q.delete(); wait_q.delete(); exp_q.delete();
        n_ret = 0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic run_stream(input int n, input string nm);
        for (int i = 0; i < n; i++) issue($urandom_range(0, 5));
        issue(0);
        bus.run = 1'b1;
        wait_fetched(3000, nm);
        // Drop run while the final R-type sits in EXEC.
        wait_state(4'd3, 50, "final_in_exec");
        bus.run = 1'b0;
        wait_retired(100, nm);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int prev, cnt;
        bus.run = 1'b0; bus.opcode = 7'd0; bus.funct3 = 3'd0;
        bus.mem_ready = 1'b0; bus.alu_zero = 1'b0; bus.alu_lt = 1'b0;
        rst_n = 1'b0;
        clear_acc();

        repeat (2) tick();
        chk("reset_outputs", outvec(), 32'd0);
        chk("reset_instret", bus.instret, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_reset_outputs", outvec(), 32'd0);

        // Random stream ending with run dropped in EXEC
        run_stream(40, "stream1");
        chk("idle_after_run_drop", bus.state, 4'd0);
        repeat (3) tick();
        chk("idle_hold", bus.state, 4'd0);
        chk("idle_no_memreq", bus.mem_req, 1'b0);

        // Reissue: FETCH the cycle after run returns
        issue(1);
        bus.run = 1'b1;
        tick();
        chk("fetch_after_run", bus.state, 4'd1);
        wait_fetched(50, "reissue");
        bus.run = 1'b0;
        wait_retired(50, "reissue");

        // Reset during a store's memory wait
        push_raw(7'b0100011, 3'b010, 1'b0, 1'b0);
        wait_q.push_back(0);
        wait_q.push_back(8);
        bus.run = 1'b1;
        wait_fetched(50, "sw_fetch");
        bus.run = 1'b0;
        wait_state(4'd5, 20, "sw_in_mem");
        tick(); tick();
        chk("sw_wait_memreq", bus.mem_req, 1'b1);
        chk("sw_wait_memwe", bus.mem_we, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_memreq_drop", bus.mem_req, 1'b0);
        chk("rst_memwe_drop", bus.mem_we, 1'b0);
        chk("rst_state_idle", bus.state, 4'd0);
        chk("rst_instret_zero", bus.instret, 32'd0);
        instr_q.delete(); wait_q.delete(); exp_q.delete();
        n_ret = 0;
        tick();
        rst_n = 1'b1;
        tick();

        // Illegal opcode, then an unsupported branch funct3
        for (int t = 0; t < 2; t++) begin
            run_stream(3, "pre_trap");
            prev = n_ret;
            if (t == 0) push_raw(7'b1110011, 3'b000, 1'b0, 1'b0);
            else        push_raw(7'b1100011, 3'b010, 1'b0, 1'b0);
            wait_q.push_back(0);
            bus.run = 1'b1;
            wait_state(4'd9, 30, "trap_entry");
            chk("trap_illegal", bus.illegal, 1'b1);
            chk("trap_instret", bus.instret, prev);
            cnt = 0;
            for (int i = 0; i < 6; i++) begin
                tick();
                if (bus.mem_req || bus.retire) cnt++;
            end
            chk("trap_quiet", cnt, 0);
            chk("trap_sticky", bus.state, 4'd9);
            bus.run = 1'b0;
            do_reset();
            chk("trap_cleared", bus.illegal, 1'b0);
            chk("trap_reset_state", bus.state, 4'd0);
        end

        // Recovery after the trap
        run_stream(12, "stream2");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
